// File: rtl/bin_to_bcd_digits_pkg.sv
// Shared types and constants for the binary-to-BCD display converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_W          = 4;
    localparam int BCD_ADJ_THRESH = 5;
    localparam int BCD_ADJ        = 3;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more before it is doubled.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] digit_in,
    output logic [BCD_W-1:0] digit_out
);

    assign digit_out = (digit_in >= BCD_W'(BCD_ADJ_THRESH)) ? digit_in + BCD_W'(BCD_ADJ)
                                                            : digit_in;

endmodule

// File: rtl/bin_to_bcd_digits.sv
// Iterative double-dabble binary-to-BCD converter with start/done handshake and held outputs.
// Optional leading-zero blank mask is built only when BCD_LEADING_BLANK_EN is defined.
module bin_to_bcd_digits
    import bcd_pkg::*;
#(
    parameter int IN_WIDTH = 16,
    parameter int DIGITS   = 5
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [IN_WIDTH-1:0]       bin_in,
    output logic                      busy,
    output logic                      done,
    output logic [BCD_W*DIGITS-1:0]   bcd_out,
    output logic                      overflow,
    output logic [DIGITS-1:0]         blank
);

    localparam int CNT_W = $clog2(IN_WIDTH + 1);
    localparam int BCD_TOT = BCD_W * DIGITS;

    state_t                state_reg, state_next;
    logic [IN_WIDTH-1:0]   shift_reg;
    logic [BCD_TOT-1:0]    bcd_scratch_reg;
    logic                  ovf_scratch_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic [BCD_TOT-1:0]    bcd_out_reg;
    logic                  overflow_reg;

    logic [BCD_TOT-1:0]    bcd_adj;
    logic [BCD_TOT-1:0]    bcd_shift_next;
    logic [IN_WIDTH-1:0]   shift_next;
    logic                  ovf_next;
    logic                  last_shift;
    logic                  load_en;
    logic                  shift_en;
    logic                  commit_en;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_digit_adjust u_adj (
                .digit_in  (bcd_scratch_reg[BCD_W*gi +: BCD_W]),
                .digit_out (bcd_adj[BCD_W*gi +: BCD_W])
            );
        end
    endgenerate

    // The bit leaving the top digit is worth 10^DIGITS, so it only feeds the sticky overflow.
    assign bcd_shift_next = {bcd_adj[BCD_TOT-2:0], shift_reg[IN_WIDTH-1]};
    assign ovf_next       = ovf_scratch_reg | bcd_adj[BCD_TOT-1];
    assign shift_next     = shift_reg << 1;
    assign last_shift     = (cnt_reg == CNT_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        load_en    = 1'b0;
        shift_en   = 1'b0;
        commit_en  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    load_en    = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy     = 1'b1;
                shift_en = 1'b1;
                if (last_shift) begin
                    commit_en  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef BCD_LEADING_BLANK_EN
    logic [DIGITS-1:0] blank_reg;
    logic [DIGITS-1:0] blank_calc;

    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_blank
            if (gi == 0) begin : g_lsd
                assign blank_calc[gi] = 1'b0;
            end else begin : g_upper
                assign blank_calc[gi] = ~ovf_next &&
                                        (bcd_shift_next[BCD_TOT-1:BCD_W*gi] == '0);
            end
        end
    endgenerate

    assign blank = blank_reg;
`else
    assign blank = '0;
`endif

    // Results are committed on the final shift so they are valid for the whole done cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg       <= '0;
            bcd_scratch_reg <= '0;
            ovf_scratch_reg <= 1'b0;
            cnt_reg         <= '0;
            bcd_out_reg     <= '0;
            overflow_reg    <= 1'b0;
`ifdef BCD_LEADING_BLANK_EN
            blank_reg       <= '0;
`endif
        end else begin
            if (load_en) begin
                shift_reg       <= bin_in;
                bcd_scratch_reg <= '0;
                ovf_scratch_reg <= 1'b0;
                cnt_reg         <= CNT_W'(IN_WIDTH);
            end else if (shift_en) begin
                shift_reg       <= shift_next;
                bcd_scratch_reg <= bcd_shift_next;
                ovf_scratch_reg <= ovf_next;
                cnt_reg         <= cnt_reg - CNT_W'(1);
            end
            if (commit_en) begin
                bcd_out_reg  <= bcd_shift_next;
                overflow_reg <= ovf_next;
`ifdef BCD_LEADING_BLANK_EN
                blank_reg    <= blank_calc;
`endif
            end
        end
    end

    assign bcd_out  = bcd_out_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_bin_to_bcd_digits.sv
// Directed bench for bin_to_bcd_digits: 5-digit and 3-digit instances, table vectors plus handshake/reset sequences.
module tb_bin_to_bcd_digits;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;

    logic        start5 = 1'b0;
    logic [15:0] bin5 = '0;
    logic        busy5, done5, ovf5;
    logic [19:0] bcd5;
    logic [4:0]  blank5;

    logic        start3 = 1'b0;
    logic [15:0] bin3 = '0;
    logic        busy3, done3, ovf3;
    logic [11:0] bcd3;
    logic [2:0]  blank3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bin_to_bcd_digits #(.IN_WIDTH(16), .DIGITS(5)) dut5 (
        .clk(clk), .reset_n(reset_n), .start(start5), .bin_in(bin5),
        .busy(busy5), .done(done5), .bcd_out(bcd5), .overflow(ovf5), .blank(blank5)
    );

    bin_to_bcd_digits #(.IN_WIDTH(16), .DIGITS(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .start(start3), .bin_in(bin3),
        .busy(busy3), .done(done3), .bcd_out(bcd3), .overflow(ovf3), .blank(blank3)
    );

    typedef struct {
        logic [15:0] bin;
        logic [19:0] bcd;
        logic        ovf;
        logic [4:0]  blank;   // mask expected with leading blanking enabled
    } vec_t;

    vec_t v5[10];
    vec_t v3[5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic logic [4:0] exp_blank(input logic [4:0] b);
`ifdef BCD_LEADING_BLANK_EN
        return b;
`else
        return 5'b0 & b;
`endif
    endfunction

    // Starts a conversion and returns at the negedge of the done cycle; lat = cycles after start, -1 on timeout.
    task automatic convert(input int sel, input logic [15:0] v, output int lat);
        lat = -1;
        if (sel == 0) begin start5 = 1'b1; bin5 = v; end
        else          begin start3 = 1'b1; bin3 = v; end
        @(posedge clk); #1;
        start5 = 1'b0;
        start3 = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if ((sel == 0) ? done5 : done3) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int pulses;
        logic [19:0] seen_bcd;

        v5[0] = '{16'd0,     20'h00000, 1'b0, 5'b11110};
        v5[1] = '{16'd65535, 20'h65535, 1'b0, 5'b00000};
        v5[2] = '{16'd1234,  20'h01234, 1'b0, 5'b10000};
        v5[3] = '{16'd42,    20'h00042, 1'b0, 5'b11100};
        v5[4] = '{16'd9,     20'h00009, 1'b0, 5'b11110};
        v5[5] = '{16'd10,    20'h00010, 1'b0, 5'b11100};
        v5[6] = '{16'd100,   20'h00100, 1'b0, 5'b11000};
        v5[7] = '{16'd9999,  20'h09999, 1'b0, 5'b10000};
        v5[8] = '{16'd10000, 20'h10000, 1'b0, 5'b00000};
        v5[9] = '{16'd50505, 20'h50505, 1'b0, 5'b00000};

        v3[0] = '{16'd1000,  20'h00000, 1'b1, 5'b00000};
        v3[1] = '{16'd999,   20'h00999, 1'b0, 5'b00000};
        v3[2] = '{16'd65535, 20'h00535, 1'b1, 5'b00000};
        v3[3] = '{16'd5,     20'h00005, 1'b0, 5'b00110};
        v3[4] = '{16'd0,     20'h00000, 1'b0, 5'b00110};

        #2 reset_n = 1'b0;
        #1;
        check("reset_busy",  32'(busy5),  32'd0);
        check("reset_done",  32'(done5),  32'd0);
        check("reset_bcd",   32'(bcd5),   32'd0);
        check("reset_ovf",   32'(ovf5),   32'd0);
        check("reset_blank", 32'(blank5), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            convert(0, v5[i].bin, lat);
            $display("d5 bin=%0d bcd=%05h ovf=%0b blank=%05b lat=%0d", v5[i].bin, bcd5, ovf5, blank5, lat);
            check("d5_latency", 32'(lat),    32'd17);
            check("d5_bcd",     32'(bcd5),   32'(v5[i].bcd));
            check("d5_ovf",     32'(ovf5),   32'(v5[i].ovf));
            check("d5_blank",   32'(blank5), 32'(exp_blank(v5[i].blank)));
            @(posedge clk); #1;
            check("d5_done_pulse_width", 32'(done5), 32'd0);
        end

        for (int i = 0; i < 5; i++) begin
            convert(1, v3[i].bin, lat);
            $display("d3 bin=%0d bcd=%03h ovf=%0b blank=%03b lat=%0d", v3[i].bin, bcd3, ovf3, blank3, lat);
            check("d3_latency", 32'(lat),    32'd17);
            check("d3_bcd",     32'(bcd3),   32'(v3[i].bcd));
            check("d3_ovf",     32'(ovf3),   32'(v3[i].ovf));
            check("d3_blank",   32'(blank3), 32'(exp_blank(v3[i].blank) & 5'b00111));
            @(posedge clk); #1;
        end

        // start held for 10 cycles with changing bin_in: only the first value converts
        for (int i = 0; i < 10; i++) begin
            start5 = 1'b1;
            bin5   = 16'(321 + i * 111);
            @(posedge clk); #1;
            check("held_busy", 32'(busy5), 32'd1);
            check("held_bcd_stable", 32'(bcd5), 32'h50505);
        end
        start5 = 1'b0;
        pulses = 0;
        seen_bcd = '0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (done5) begin
                pulses++;
                seen_bcd = bcd5;
            end
        end
        $display("held start pulses=%0d bcd=%05h", pulses, seen_bcd);
        check("held_done_count", 32'(pulses),   32'd1);
        check("held_bcd",        32'(seen_bcd), 32'h00321);

        // start raised during the done cycle is ignored, accepted one cycle later
        convert(0, 16'd77, lat);
        check("done_start_lat", 32'(lat), 32'd17);
        start5 = 1'b1;
        bin5   = 16'd99;
        @(posedge clk); #1;
        check("done_start_ignored", 32'(busy5), 32'd0);
        convert(0, 16'd99, lat);
        $display("start after done bcd=%05h lat=%0d", bcd5, lat);
        check("done_start_lat2", 32'(lat),  32'd17);
        check("done_start_bcd",  32'(bcd5), 32'h00099);
        @(posedge clk); #1;

        // reset in cycle 8 of a conversion aborts it without a done pulse
        start5 = 1'b1;
        bin5   = 16'd4321;
        @(posedge clk); #1;
        start5 = 1'b0;
        for (int n = 0; n < 7; n++) begin
            @(posedge clk);
        end
        #1;
        reset_n = 1'b0;
        #1;
        $display("mid reset busy=%0b done=%0b bcd=%05h", busy5, done5, bcd5);
        check("midrst_busy", 32'(busy5), 32'd0);
        check("midrst_done", 32'(done5), 32'd0);
        check("midrst_bcd",  32'(bcd5),  32'd0);
        check("midrst_ovf",  32'(ovf5),  32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (done5 || busy5) pulses++;
        end
        check("midrst_no_done", 32'(pulses), 32'd0);
        @(posedge clk); #1;
        convert(0, 16'd7, lat);
        $display("after reset bcd=%05h lat=%0d", bcd5, lat);
        check("postrst_lat", 32'(lat),  32'd17);
        check("postrst_bcd", 32'(bcd5), 32'h00007);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
